// File: rtl/jtag_tap_responder_if.sv
// jtag_tap_responder_if
//   JTAG pin bundle between a JTAG master and the TAP responder.
//   master modport: drives tck/tms/tdi/trst, observes tdo/tdo_oe.
//   slave  modport: the responder side (samples tck/tms/tdi/trst, drives tdo/tdo_oe).
interface jtag_tap_responder_if;
    logic jtag_tck;   // JTAG clock, asynchronous to the system clock
    logic jtag_tms;   // mode select
    logic jtag_tdi;   // serial data into the target
    logic jtag_trst;  // active-high TAP reset
    logic jtag_tdo;   // serial data out of the target
    logic tdo_oe;     // high while the target is in Shift-IR / Shift-DR

    modport master (
        output jtag_tck, jtag_tms, jtag_tdi, jtag_trst,
        input  jtag_tdo, tdo_oe
    );

    modport slave (
        input  jtag_tck, jtag_tms, jtag_tdi, jtag_trst,
        output jtag_tdo, tdo_oe
    );
endinterface

// File: rtl/jtag_tap_responder.sv
// jtag_tap_responder
//   Target-side IEEE 1149.1 TAP. TCK/TMS/TDI/TRST are oversampled on clk
//   (clk >= 6x TCK), the 16-state TAP controller advances on each detected
//   TCK rise, and TDO is updated on each detected TCK fall.
//   Registers: IR (IR_LEN bits), BYPASS (1 bit), IDCODE (32 bits) and an
//   optional 32-bit user DR sharing the IDCODE shift register.
//
//   Optional feature macro: JTAG_TAP_USER_DR_EN
//     defined   : USER opcode (4'h8) selects the user DR; user_dr_out,
//                 user_capture and user_update are live.
//     undefined : USER decodes as BYPASS; those outputs are tied 0.
//
//   Ports
//     clk, rst      system clock, asynchronous active-high reset
//     jtag          JTAG pins (slave modport of jtag_tap_responder_if)
//     tap_state     current TAP state, IEEE encoding
//     ir_value      current instruction
//     user_dr_in    parallel value captured into the user DR at Capture-DR
//     user_dr_out   user DR contents latched at Update-DR
//     user_capture  one-clk pulse after the rise leaving Capture-DR (USER)
//     user_update   one-clk pulse after the rise leaving Update-DR (USER)
module jtag_tap_responder #(
    parameter logic [31:0] IDCODE = 32'h4A7A_6001,
    parameter int          IR_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,
    jtag_tap_responder_if.slave jtag,
    output logic [3:0]        tap_state,
    output logic [IR_LEN-1:0] ir_value,
    input  logic [31:0]       user_dr_in,
    output logic [31:0]       user_dr_out,
    output logic              user_capture,
    output logic              user_update
);

    typedef enum logic [3:0] {
        TLR      = 4'hF, RTI      = 4'hC,
        SEL_DR   = 4'h7, CAP_DR   = 4'h6, SH_DR  = 4'h2, EX1_DR = 4'h1,
        PAUSE_DR = 4'h3, EX2_DR   = 4'h0, UPD_DR = 4'h5,
        SEL_IR   = 4'h4, CAP_IR   = 4'hE, SH_IR  = 4'hA, EX1_IR = 4'h9,
        PAUSE_IR = 4'hB, EX2_IR   = 4'h8, UPD_IR = 4'hD
    } tap_state_e;

    localparam logic [IR_LEN-1:0] OP_IDCODE = IR_LEN'(4'hE);

    // ------------------------------------------------------------------
    // Synchronisers. TMS/TDI have the same depth as TCK so that *_s2 is
    // the value present when tck_s2 first shows the rise.
    // ------------------------------------------------------------------
    logic tck_s1, tck_s2, tck_s3;
    logic tms_s1, tms_s2;
    logic tdi_s1, tdi_s2;
    logic trst_s1, trst_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tck_s1  <= 1'b0; tck_s2  <= 1'b0; tck_s3 <= 1'b0;
            tms_s1  <= 1'b0; tms_s2  <= 1'b0;
            tdi_s1  <= 1'b0; tdi_s2  <= 1'b0;
            trst_s1 <= 1'b0; trst_s2 <= 1'b0;
        end else begin
            tck_s1  <= jtag.jtag_tck;  tck_s2  <= tck_s1;  tck_s3 <= tck_s2;
            tms_s1  <= jtag.jtag_tms;  tms_s2  <= tms_s1;
            tdi_s1  <= jtag.jtag_tdi;  tdi_s2  <= tdi_s1;
            trst_s1 <= jtag.jtag_trst; trst_s2 <= trst_s1;
        end
    end

    logic tck_rise, tck_fall;
    assign tck_rise =  tck_s2 & ~tck_s3;
    assign tck_fall = ~tck_s2 &  tck_s3;

    // ------------------------------------------------------------------
    // TAP controller
    // ------------------------------------------------------------------
    tap_state_e state, nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= TLR;
        else if (trst_s2)
            state <= TLR;          // trst beats a coincident TCK rise
        else if (tck_rise)
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            TLR:      nxt = tms_s2 ? TLR      : RTI;
            RTI:      nxt = tms_s2 ? SEL_DR   : RTI;
            SEL_DR:   nxt = tms_s2 ? SEL_IR   : CAP_DR;
            CAP_DR:   nxt = tms_s2 ? EX1_DR   : SH_DR;
            SH_DR:    nxt = tms_s2 ? EX1_DR   : SH_DR;
            EX1_DR:   nxt = tms_s2 ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: nxt = tms_s2 ? EX2_DR   : PAUSE_DR;
            EX2_DR:   nxt = tms_s2 ? UPD_DR   : SH_DR;
            UPD_DR:   nxt = tms_s2 ? SEL_DR   : RTI;
            SEL_IR:   nxt = tms_s2 ? TLR      : CAP_IR;
            CAP_IR:   nxt = tms_s2 ? EX1_IR   : SH_IR;
            SH_IR:    nxt = tms_s2 ? EX1_IR   : SH_IR;
            EX1_IR:   nxt = tms_s2 ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: nxt = tms_s2 ? EX2_IR   : PAUSE_IR;
            EX2_IR:   nxt = tms_s2 ? UPD_IR   : SH_IR;
            UPD_IR:   nxt = tms_s2 ? SEL_DR   : RTI;
            default:  nxt = TLR;
        endcase
    end

    assign tap_state   = state;
    assign jtag.tdo_oe = (state == SH_IR) || (state == SH_DR);

    // ------------------------------------------------------------------
    // Instruction decode. Anything that is neither IDCODE nor USER
    // (when enabled) selects the 1-bit bypass register.
    // ------------------------------------------------------------------
    logic sel_idcode, sel_user, sel_wide;

    assign sel_idcode = (ir_value == OP_IDCODE);
`ifdef JTAG_TAP_USER_DR_EN
    localparam logic [IR_LEN-1:0] OP_USER = IR_LEN'(4'h8);
    assign sel_user = (ir_value == OP_USER);
`else
    assign sel_user = 1'b0;
`endif
    // IDCODE and the user DR share one 32-bit shift register.
    assign sel_wide = sel_idcode | sel_user;

    // ------------------------------------------------------------------
    // Shift registers, IR, pulses and TDO. All actions key off the state
    // held before the rise is applied.
    // ------------------------------------------------------------------
    logic [IR_LEN-1:0] ir_sr;
    logic [31:0]       dr_sr;
    logic              byp_sr;
    logic              tdo_q;
    logic              ir_path;

    assign ir_path = (state == SH_IR) || (state == EX1_IR) ||
                     (state == PAUSE_IR) || (state == EX2_IR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_sr        <= '0;
            dr_sr        <= '0;
            byp_sr       <= 1'b0;
            ir_value     <= OP_IDCODE;
            user_capture <= 1'b0;
            user_update  <= 1'b0;
            tdo_q        <= 1'b0;
        end else begin
            user_capture <= 1'b0;
            user_update  <= 1'b0;
            if (trst_s2) begin
                ir_value <= OP_IDCODE;
            end else if (tck_rise) begin
                case (state)
                    CAP_IR: ir_sr <= IR_LEN'(2'b01);
                    SH_IR:  ir_sr <= {tdi_s2, ir_sr[IR_LEN-1:1]};
                    UPD_IR: ir_value <= ir_sr;
                    CAP_DR: begin
                        byp_sr <= 1'b0;
                        if (sel_idcode)
                            dr_sr <= IDCODE;
                        else if (sel_user)
                            dr_sr <= user_dr_in;
                        user_capture <= sel_user;
                    end
                    SH_DR: begin
                        if (sel_wide)
                            dr_sr <= {tdi_s2, dr_sr[31:1]};
                        else
                            byp_sr <= tdi_s2;
                    end
                    UPD_DR: user_update <= sel_user;
                    default: ;
                endcase
                if (nxt == TLR)
                    ir_value <= OP_IDCODE;
            end
            if (tck_fall)
                tdo_q <= ir_path ? ir_sr[0] : (sel_wide ? dr_sr[0] : byp_sr);
        end
    end

    assign jtag.jtag_tdo = tdo_q;

`ifdef JTAG_TAP_USER_DR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            user_dr_out <= '0;
        else if (!trst_s2 && tck_rise && state == UPD_DR && sel_user)
            user_dr_out <= dr_sr;
    end
`else
    assign user_dr_out = '0;
`endif

endmodule

// File: tb/tb_jtag_tap_responder.sv
// tb_jtag_tap_responder
//   Directed bench for jtag_tap_responder. Acts as the JTAG master: each
//   TCK phase lasts 4 clk, TDO is sampled just before each TCK rise.
module tb_jtag_tap_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  tap_state;
    logic [3:0]  ir_value;
    logic [31:0] user_dr_in;
    logic [31:0] user_dr_out;
    logic        user_capture, user_update;

    jtag_tap_responder_if jif ();

    jtag_tap_responder #(.IDCODE(32'h4A7A_6001), .IR_LEN(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .jtag         (jif.slave),
        .tap_state    (tap_state),
        .ir_value     (ir_value),
        .user_dr_in   (user_dr_in),
        .user_dr_out  (user_dr_out),
        .user_capture (user_capture),
        .user_update  (user_update)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int oe_cnt = 0;
    int cap_cnt = 0;
    int upd_cnt = 0;

    // Clock cycles each pulse is high.
    always @(posedge clk) begin
        if (user_capture) cap_cnt <= cap_cnt + 1;
        if (user_update)  upd_cnt <= upd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One TCK cycle; returns TDO as seen just before the rise.
    task automatic tck_pulse(input logic tms_v, input logic tdi_v, output logic tdo_s);
        @(negedge clk);
        jif.jtag_tms = tms_v;
        jif.jtag_tdi = tdi_v;
        repeat (4) @(negedge clk);
        tdo_s = jif.jtag_tdo;
        if (jif.tdo_oe) oe_cnt++;
        jif.jtag_tck = 1'b1;
        repeat (4) @(negedge clk);
        jif.jtag_tck = 1'b0;
    endtask

    // TMS sequence, bit 0 first, TDI held 0.
    task automatic go(input logic [15:0] bits, input int n);
        logic s;
        for (int i = 0; i < n; i++) tck_pulse(bits[i], 1'b0, s);
    endtask

    // n-bit shift, LSB first, TMS=1 on the last bit.
    task automatic shift(input logic [31:0] din, input int n, output logic [31:0] dout);
        logic s;
        dout = '0;
        for (int i = 0; i < n; i++) begin
            tck_pulse(i == n - 1, din[i], s);
            dout[i] = s;
        end
    endtask

    logic [7:0]  pb [16];
    int          pn [16];
    logic [3:0]  ps [16];
    logic [31:0] d;
    logic        s;
    int          cap0, upd0;

    initial begin
        // Paths from TLR to each state (TMS bit 0 first).
        pb = '{8'h00, 8'h00, 8'h02, 8'h02, 8'h02, 8'h0A, 8'h0A, 8'h2A,
               8'h1A, 8'h06, 8'h06, 8'h06, 8'h16, 8'h16, 8'h56, 8'h36};
        pn = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6};
        ps = '{4'hF, 4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h3, 4'h0,
               4'h5, 4'h4, 4'hE, 4'hA, 4'h9, 4'hB, 4'h8, 4'hD};

        rst = 1'b1;
        jif.jtag_tck = 1'b0; jif.jtag_tms = 1'b1;
        jif.jtag_tdi = 1'b0; jif.jtag_trst = 1'b0;
        user_dr_in = 32'h1234_5678;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_state", tap_state, 4'hF);
        chk("rst_ir", ir_value, 4'hE);
        chk("rst_tdo", jif.jtag_tdo, 1'b0);
        chk("rst_oe", jif.tdo_oe, 1'b0);
        chk("rst_udr", user_dr_out, 32'h0);
        chk("rst_cap", user_capture, 1'b0);
        chk("rst_upd", user_update, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Every state reachable, and 5x TMS=1 returns to TLR with IDCODE
        for (int k = 0; k < 16; k++) begin
            go({8'h00, pb[k]}, pn[k]);
            chk($sformatf("reach_%0d", k), tap_state, ps[k]);
            go(16'h001F, 5);
            chk($sformatf("tlr_state_%0d", k), tap_state, 4'hF);
            chk($sformatf("tlr_ir_%0d", k), ir_value, 4'hE);
        end

        // IDCODE read
        go(16'h0002, 4);
        oe_cnt = 0;
        shift(32'h0, 32, d);
        chk("idcode", d, 32'h4A7A_6001);
        chk("idcode_oe", oe_cnt, 32);
        go(16'h0001, 2);
        chk("idcode_rti", tap_state, 4'hC);

        // IR scan of BYPASS, then 8-bit DR shift through bypass
        go(16'h0006, 5);
        shift(32'hF, 4, d);
        chk("ir_capture", d[3:0], 4'b0001);
        go(16'h0003, 2);
        chk("ir_bypass", ir_value, 4'hF);
        go(16'h0000, 2);
        shift(32'hA5, 8, d);
        chk("bypass_8", d[7:0], 8'h4A);
        tck_pulse(1'b1, 1'b0, s);
        chk("bypass_last", s, 1'b1);
        go(16'h0000, 1);

        // USER instruction
        go(16'h0006, 5);
        shift(32'h8, 4, d);
        go(16'h0003, 2);
        chk("ir_user", ir_value, 4'h8);
        cap0 = cap_cnt; upd0 = upd_cnt;
        go(16'h0000, 2);
        shift(32'hDEAD_BEEF, 32, d);
        go(16'h0001, 2);
`ifdef JTAG_TAP_USER_DR_EN
        chk("user_read", d, 32'h1234_5678);
        chk("user_dr_out", user_dr_out, 32'hDEAD_BEEF);
        chk("user_cap_pulse", cap_cnt - cap0, 1);
        chk("user_upd_pulse", upd_cnt - upd0, 1);
`else
        chk("user_read", d, 32'hBD5B_7DDE);
        chk("user_dr_out", user_dr_out, 32'h0);
        chk("user_cap_pulse", cap_cnt - cap0, 0);
        chk("user_upd_pulse", upd_cnt - upd0, 0);
`endif

        // rst in the middle of an IDCODE shift
        go(16'h001F, 5);
        go(16'h0002, 4);
        go(16'h0000, 13);
        chk("mid_shdr", tap_state, 4'h2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_state", tap_state, 4'hF);
        chk("mid_rst_ir", ir_value, 4'hE);
        chk("mid_rst_tdo", jif.jtag_tdo, 1'b0);
        chk("mid_rst_oe", jif.tdo_oe, 1'b0);
        chk("mid_rst_udr", user_dr_out, 32'h0);
        chk("mid_rst_cap", user_capture, 1'b0);
        chk("mid_rst_upd", user_update, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        go(16'h0002, 4);
        shift(32'h0, 32, d);
        chk("idcode_after_rst", d, 32'h4A7A_6001);
        go(16'h0001, 2);

        // trst pulse while in Shift-IR with a non-IDCODE instruction loaded
        go(16'h0006, 5);
        shift(32'hF, 4, d);
        go(16'h0001, 2);
        chk("trst_pre_ir", ir_value, 4'hF);
        go(16'h0006, 5);
        go(16'h0000, 2);
        chk("trst_shir", tap_state, 4'hA);
        chk("trst_shir_oe", jif.tdo_oe, 1'b1);
        @(negedge clk);
        jif.jtag_trst = 1'b1;
        repeat (4) @(negedge clk);
        jif.jtag_trst = 1'b0;
        repeat (3) @(negedge clk);
        chk("trst_state", tap_state, 4'hF);
        chk("trst_ir", ir_value, 4'hE);
        chk("trst_oe", jif.tdo_oe, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/jtag_tap_responder.md
# jtag_tap_responder

Target-side IEEE 1149.1 TAP responder: the far end of the PMU's JTAG master. It oversamples TCK/TMS/TDI on the system clock, runs the 16-state TAP controller, and implements IR, BYPASS, IDCODE and an optional 32-bit user data register. It drives TDO back to the master. It serves as the on-FPGA loopback target for JTAG self-test and as a simulation model for the sequence engine's bench.

## Interface
- IDCODE, 32'h4A7A_6001, value captured in Capture-DR under IDCODE; bit 0 must be 1.
- IR_LEN, 4, instruction register width; minimum 2.
- clk  in  1  system clock; must run at least 6× TCK.
- rst  in  1  asynchronous, active-high reset.
- jtag_tck  in  1  JTAG clock, asynchronous to clk.
- jtag_tms  in  1  mode select.
- jtag_tdi  in  1  serial data in.
- jtag_trst  in  1  active-high TAP reset; synchronised, forces Test-Logic-Reset.
- jtag_tdo  out  1  serial data out.
- tdo_oe  out  1  high while in Shift-IR or Shift-DR.
- tap_state  out  4  current TAP state (IEEE encoding, below).
- ir_value  out  IR_LEN  current instruction.
- user_dr_in  in  32  parallel value captured into the user DR.
- user_dr_out  out  32  user DR contents latched at Update-DR.
- user_capture  out  1  one-clk pulse at Capture-DR with USER selected.
- user_update  out  1  one-clk pulse at Update-DR with USER selected.

## Operation
- TCK, TMS, TDI and TRST each pass through two-flop synchronisers. A third TCK flop provides edge detection: rise = s2 & ~s3, fall = ~s2 & s3. TMS/TDI use the same sync depth, so they are sampled aligned to the rise.
- State encoding: TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D. Transitions follow standard 1149.1 on each rise using synced TMS.
- Actions on the rise, based on the state *before* the transition:
  - CapIR loads IR shift register with {0…,2'b01}.
  - ShIR shifts right with TDI into MSB.
  - CapDR loads the selected DR: IDCODE → IDCODE, BYPASS → 0, USER → user_dr_in.
  - ShDR shifts the selected DR right with TDI into MSB. BYPASS is 1 bit.
  - UpdIR copies the IR shift register to ir_value.
  - UpdDR with USER copies the shift register to user_dr_out.
- Instructions: 4'hE IDCODE, 4'h8 USER, 4'hF BYPASS. Any other code acts as BYPASS. Entering TLR forces ir_value = IDCODE opcode (zero-extended/truncated to IR_LEN).
- TDO: on each fall, jtag_tdo is set to bit 0 of the active shift register (IR in IR-shift states, else selected DR). Otherwise it holds its last value. tdo_oe follows tap_state combinationally (ShIR/ShDR).
- jtag_trst high (synced) forces TLR and IDCODE regardless of TCK, and suppresses capture/update pulses.

## Timing
- Reset values: tap_state=F, ir_value=IDCODE opcode, jtag_tdo=0, tdo_oe=0, user_dr_out=0, user_capture=0, user_update=0, all shift registers 0.
- TCK rise → state update visible: 3 clk. TCK fall → jtag_tdo valid: 3 clk (4 including output flop is not allowed; TDO is registered once).
- TCK high and low phases must each be ≥3 clk. Shorter pulses may be missed; no error is flagged.
- user_capture/user_update assert in the clk after the rise that leaves CapDR/UpdDR, for exactly one clk.
- TDI sampled on a rise while in ShDR is the bit shifted in; the last bit is taken on the rise that moves ShDR→Ex1DR.
- rst mid-shift: immediate return to reset values; partial shift data is discarded and user_dr_out is cleared.
- Simultaneous trst and TCK rise: trst wins; state = TLR.

## Configuration
- JTAG_TAP_USER_DR_EN defined: 32-bit user DR, USER opcode, user_capture/user_update/user_dr_out are active.
- Not defined: USER decodes as BYPASS, user_dr_out is tied 0, and pulses are tied 0. The ports remain present.

## Test plan
- From each of the 16 states, 5 TCKs with TMS=1 → tap_state=F, ir_value=4'hE.
- After rst: TMS 0,1,0,0 then 32 ShDR clocks (TMS=1 on last) → TDO stream 0x4A7A6001 LSB first; tdo_oe high for exactly 32 bits.
- IR scan of 4'hF while reading TDO → TDO returns 0001 (captured); then a DR shift of 8'hA5 → TDO yields 0 followed by A5 delayed 1 bit.
- With EN: IR=4'h8, user_dr_in=0x12345678, shift in 0xDEADBEEF → TDO reads 0x12345678; user_dr_out=0xDEADBEEF after UpdDR; each pulse high 1 clk.
- Without EN: the same sequence → 1-bit bypass behaviour, user_dr_out stays 0.
- rst asserted mid-ShDR (bit 13) → all outputs at reset values next clk; subsequent IDCODE read is correct. jtag_trst pulse in ShIR → TLR, IR=IDCODE.
